// File: rtl/plic_irq_conditioner.sv
// Per-source PLIC gateway: input conditioning, edge counting and claim/complete FSM.
// `define PLIC_IRQ_COND_SYNC_EN adds a SYNC_STAGES-deep input synchronizer.
module plic_irq_conditioner #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_WIDTH   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 irq_source_i,
  input  logic                 edge_mode_i,
  input  logic                 claim_i,
  input  logic                 completed_i,
  output logic                 irq_pending_o,
  output logic [CNT_WIDTH-1:0] edge_count_o,
  output logic                 overflow_o
);

`ifdef PLIC_IRQ_COND_SYNC_EN
  localparam bit SyncEn = 1'b1;
`else
  localparam bit SyncEn = 1'b0;
`endif
  localparam int unsigned SyncDepth = SyncEn ? SYNC_STAGES : 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    CLAIMED = 2'd2
  } state_e;

  logic                 sync;
  logic                 prev_q;
  logic                 edge_det;
  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 claim_acc;
  logic                 cnt_nz;
  logic                 cnt_sat;

  if (SyncDepth == 0) begin : g_nosync
    assign sync = irq_source_i;
  end else begin : g_sync
    logic [SyncDepth-1:0] sync_q;
    always_ff @(posedge clk_i) begin
      if (rst_i) sync_q <= '0;
      else       sync_q <= (sync_q << 1) | SyncDepth'(irq_source_i);
    end
    assign sync = sync_q[SyncDepth-1];
  end

  // prev is cleared by reset, so a line already high afterwards reads as a new edge
  always_ff @(posedge clk_i) begin
    if (rst_i) prev_q <= 1'b0;
    else       prev_q <= sync;
  end

  assign edge_det  = sync & ~prev_q;
  assign claim_acc = (state_q == PENDING) & claim_i;
  assign cnt_nz    = |cnt_q;
  assign cnt_sat   = &cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (!edge_mode_i) begin
      cnt_d = '0;
    end else if (edge_det && !claim_acc) begin
      if (cnt_sat) ovf_d = 1'b1;
      else         cnt_d = cnt_q + CNT_WIDTH'(1);
    end else if (claim_acc && !edge_det && cnt_nz) begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end
  end

  // claim has priority over a same-cycle completion while pending
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (edge_mode_i ? (cnt_nz | edge_det) : sync) state_d = PENDING;
      end
      PENDING: begin
        if (claim_i)                    state_d = CLAIMED;
        else if (!edge_mode_i && !sync) state_d = IDLE;
      end
      CLAIMED: begin
        if (completed_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign irq_pending_o = (state_q == PENDING) & ~rst_i;
  assign edge_count_o  = rst_i ? '0 : cnt_q;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_plic_irq_conditioner.sv
// Self-checking bench for plic_irq_conditioner: directed scenarios plus a randomized run
// against a cycle-level behavioural model.
module tb_plic_irq_conditioner;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_WIDTH   = 2;
`ifdef PLIC_IRQ_COND_SYNC_EN
  localparam int LAT = SYNC_STAGES;
`else
  localparam int LAT = 0;
`endif
  localparam int CMAX = (1 << CNT_WIDTH) - 1;

  logic                 clk = 1'b0;
  logic                 rst, src, mode, claim, comp;
  logic                 pend;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 ovf;
  int                   n_chk = 0;
  int                   n_fail = 0;

  always #5 clk = ~clk;

  plic_irq_conditioner #(.SYNC_STAGES(SYNC_STAGES), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk_i(clk), .rst_i(rst), .irq_source_i(src), .edge_mode_i(mode),
    .claim_i(claim), .completed_i(comp),
    .irq_pending_o(pend), .edge_count_o(cnt), .overflow_o(ovf)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input logic m);
    rst = 1'b1; src = 1'b0; mode = m; claim = 1'b0; comp = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse();
    src = 1'b1; tick();
    src = 1'b0; tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; src = 1'b0; mode = 1'b0; claim = 1'b0; comp = 1'b0;
    tick(); tick();
    n_chk++; if (pend !== 1'b0) begin n_fail++; $display("FAIL reset_pend got=%0b exp=0", pend); end
    n_chk++; if (cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
    rst = 1'b0; src = 1'b1;
    repeat (LAT + 1) tick();
    n_chk++; if (pend !== 1'b1) begin n_fail++; $display("FAIL reset_prep_pend got=%0b exp=1", pend); end
    rst = 1'b1; #1;
    n_chk++; if (pend !== 1'b0) begin n_fail++; $display("FAIL reset_during_pend got=%0b exp=0", pend); end
    tick();
    rst = 1'b0; src = 1'b0;
    tick();
    n_chk++; if (pend !== 1'b0) begin n_fail++; $display("FAIL reset_after_pend got=%0b exp=0", pend); end
  endtask

  task automatic test_level();
    do_reset(1'b0);
    src = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      tick();
      n_chk++; if (pend !== 1'b0) begin n_fail++; $display("FAIL level_early i=%0d got=%0b exp=0", i, pend); end
    end
    tick();
    n_chk++; if (pend !== 1'b1) begin n_fail++; $display("FAIL level_latency got=%0b exp=1", pend); end
    claim = 1'b1; tick(); claim = 1'b0;
    n_chk++; if (pend !== 1'b0) begin n_fail++; $display("FAIL level_claim got=%0b exp=0", pend); end
    tick();
    n_chk++; if (pend !== 1'b0) begin n_fail++; $display("FAIL level_claimed_hold got=%0b exp=0", pend); end
    comp = 1'b1; tick(); comp = 1'b0;
    n_chk++; if (pend !== 1'b0) begin n_fail++; $display("FAIL level_idle_gap got=%0b exp=0", pend); end
    tick();
    n_chk++; if (pend !== 1'b1) begin n_fail++; $display("FAIL level_repend got=%0b exp=1", pend); end
    n_chk++; if (cnt !== '0) begin n_fail++; $display("FAIL level_cnt got=%0d exp=0", cnt); end
    src = 1'b0;
  endtask

  task automatic test_retraction();
    do_reset(1'b0);
    src = 1'b1;
    repeat (4) tick();
    n_chk++; if (pend !== 1'b1) begin n_fail++; $display("FAIL retract_pre got=%0b exp=1", pend); end
    src = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      tick();
      n_chk++; if (pend !== 1'b1) begin n_fail++; $display("FAIL retract_hold i=%0d got=%0b exp=1", i, pend); end
    end
    tick();
    n_chk++; if (pend !== 1'b0) begin n_fail++; $display("FAIL retract_fall got=%0b exp=0", pend); end
    n_chk++; if (cnt !== '0) begin n_fail++; $display("FAIL retract_cnt got=%0d exp=0", cnt); end
  endtask

  task automatic test_edge_claimed();
    do_reset(1'b1);
    pulse();
    repeat (LAT) tick();
    n_chk++; if (pend !== 1'b1 || cnt !== 2'd1) begin
      n_fail++; $display("FAIL edge_first got pend=%0b cnt=%0d exp pend=1 cnt=1", pend, cnt); end
    claim = 1'b1; tick(); claim = 1'b0;
    n_chk++; if (pend !== 1'b0 || cnt !== 2'd0) begin
      n_fail++; $display("FAIL edge_claim got pend=%0b cnt=%0d exp pend=0 cnt=0", pend, cnt); end
    repeat (3) pulse();
    repeat (LAT + 1) tick();
    n_chk++; if (pend !== 1'b0 || cnt !== 2'd3) begin
      n_fail++; $display("FAIL edge_in_claimed got pend=%0b cnt=%0d exp pend=0 cnt=3", pend, cnt); end
    comp = 1'b1; tick(); comp = 1'b0;
    n_chk++; if (pend !== 1'b0) begin n_fail++; $display("FAIL edge_idle_gap got=%0b exp=0", pend); end
    tick();
    n_chk++; if (pend !== 1'b1) begin n_fail++; $display("FAIL edge_repend got=%0b exp=1", pend); end
    for (int r = 0; r < 3; r++) begin
      claim = 1'b1; tick(); claim = 1'b0;
      n_chk++; if (cnt !== CNT_WIDTH'(2 - r)) begin
        n_fail++; $display("FAIL edge_round_cnt r=%0d got=%0d exp=%0d", r, cnt, 2 - r); end
      comp = 1'b1; tick(); comp = 1'b0;
      tick();
      n_chk++; if (pend !== (r < 2)) begin
        n_fail++; $display("FAIL edge_round_pend r=%0d got=%0b exp=%0b", r, pend, (r < 2)); end
    end
  endtask

  task automatic test_overflow();
    do_reset(1'b1);
    repeat (3) pulse();
    repeat (LAT + 1) tick();
    n_chk++; if (cnt !== 2'd3 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL ovf_sat got cnt=%0d ovf=%0b exp cnt=3 ovf=0", cnt, ovf); end
    repeat (2) pulse();
    repeat (LAT + 1) tick();
    n_chk++; if (cnt !== 2'd3 || ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set got cnt=%0d ovf=%0b exp cnt=3 ovf=1", cnt, ovf); end
    mode = 1'b0; tick();
    n_chk++; if (cnt !== 2'd0 || ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_level_hold got cnt=%0d ovf=%0b exp cnt=0 ovf=1", cnt, ovf); end
    rst = 1'b1; tick(); rst = 1'b0; tick();
    n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%0b exp=0", ovf); end
  endtask

  task automatic test_collision();
    do_reset(1'b0);
    src = 1'b1;
    repeat (LAT + 1) tick();
    n_chk++; if (pend !== 1'b1) begin n_fail++; $display("FAIL coll_pre got=%0b exp=1", pend); end
    claim = 1'b1; comp = 1'b1; tick(); claim = 1'b0; comp = 1'b0;
    n_chk++; if (pend !== 1'b0) begin n_fail++; $display("FAIL coll_claim got=%0b exp=0", pend); end
    tick();
    n_chk++; if (pend !== 1'b0) begin n_fail++; $display("FAIL coll_stays_claimed got=%0b exp=0", pend); end
    src = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    comp = 1'b1; tick(); comp = 1'b0;
    tick();
    n_chk++; if (pend !== 1'b0 || cnt !== '0) begin
      n_fail++; $display("FAIL coll_reset_abandon got pend=%0b cnt=%0d exp pend=0 cnt=0", pend, cnt); end
  endtask

  task automatic test_reset_edge();
    mode = 1'b1; src = 1'b1; claim = 1'b0; comp = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    n_chk++; if (pend !== 1'b0) begin n_fail++; $display("FAIL rstedge_pre got=%0b exp=0", pend); end
    repeat (LAT + 1) tick();
    n_chk++; if (pend !== 1'b1 || cnt !== 2'd1) begin
      n_fail++; $display("FAIL rstedge got pend=%0b cnt=%0d exp pend=1 cnt=1", pend, cnt); end
    src = 1'b0;
  endtask

  task automatic test_random();
    bit dl[8];
    bit prev, m_pend, m_clm, mo, s, e, acc;
    int mc;
    rst = 1'b1; src = 1'b0; mode = 1'b0; claim = 1'b0; comp = 1'b0;
    prev = 0; m_pend = 0; m_clm = 0; mo = 0; mc = 0;
    for (int c = 0; c < 800; c++) begin
      if (c > 0) begin
        rst   = ($urandom_range(0, 99) == 0);
        if ($urandom_range(0, 39) == 0) mode = ~mode;
        if ($urandom_range(0, 2) == 0) src = ~src;
        claim = ($urandom_range(0, 3) == 0);
        comp  = ($urandom_range(0, 3) == 0);
      end
      if (rst) begin
        for (int i = 0; i < 8; i++) dl[i] = 0;
        prev = 0; m_pend = 0; m_clm = 0; mc = 0; mo = 0;
      end else begin
        s = (LAT == 0) ? src : dl[(LAT == 0) ? 0 : LAT - 1];
        for (int i = 7; i > 0; i--) dl[i] = dl[i-1];
        dl[0] = src;
        e = s & ~prev;
        prev = s;
        acc = m_pend & claim;
        if (!m_pend && !m_clm) m_pend = mode ? (mc > 0 || e) : s;
        else if (m_pend) begin
          if (claim) begin m_pend = 0; m_clm = 1; end
          else if (!mode && !s) m_pend = 0;
        end else if (comp) m_clm = 0;
        if (!mode) mc = 0;
        else if (e && !acc) begin
          if (mc == CMAX) mo = 1; else mc++;
        end else if (acc && !e && mc > 0) mc--;
      end
      tick();
      n_chk++;
      if ({pend, cnt, ovf} !== {m_pend, CNT_WIDTH'(mc), mo}) begin
        n_fail++;
        $display("FAIL random cyc=%0d got pend=%0b cnt=%0d ovf=%0b exp pend=%0b cnt=%0d ovf=%0b",
                 c, pend, cnt, ovf, m_pend, mc, mo);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_level();
    test_retraction();
    test_edge_claimed();
    test_overflow();
    test_collision();
    test_reset_edge();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/plic_irq_conditioner.md
PLIC_IRQ_CONDITIONER -- requirements
Module: plic_irq_conditioner

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 SHALL have parameter: SYNC_STAGES, 2, synchronizer depth (2..4).
REQ-003 SHALL have parameter: CNT_WIDTH, 4, width of the edge counter (1..8).
REQ-004 SHALL have port: clk_i  input  1  clock.
REQ-005 SHALL have port: rst_i  input  1  synchronous active-high reset.
REQ-006 SHALL have port: irq_source_i  input  1  raw asynchronous interrupt line from the peripheral.
REQ-007 SHALL have port: edge_mode_i  input  1  1 = edge-triggered, 0 = level-triggered.
REQ-008 SHALL have port: claim_i  input  1  one-cycle claim pulse from the claim/complete tracker.
REQ-009 SHALL have port: completed_i  input  1  one-cycle completion pulse from the claim/complete tracker.
REQ-010 SHALL have port: irq_pending_o  output  1  pending request to the target slices.
REQ-011 SHALL have port: edge_count_o  output  CNT_WIDTH  number of outstanding unclaimed edges.
REQ-012 SHALL have port: overflow_o  output  1  sticky flag: an edge was lost at counter saturation.

Function
REQ-013 SHALL pass irq_source_i through a SYNC_STAGES-deep flop chain; sync = last stage.
REQ-014 SHALL register sync into prev each cycle; edge_det = sync & ~prev.
REQ-015 SHALL implement FSM states IDLE, PENDING, CLAIMED; irq_pending_o = (state == PENDING).
REQ-016 IDLE->PENDING SHALL occur when: level mode and sync = 1; or edge mode and (edge_count_o > 0 or edge_det).
REQ-017 PENDING->CLAIMED SHALL occur on claim_i; claim_i in IDLE/CLAIMED SHALL be ignored.
REQ-018 In level mode, PENDING->IDLE SHALL occur when sync = 0 and claim_i = 0 (retraction).
REQ-019 CLAIMED->IDLE SHALL occur on completed_i; completed_i in IDLE/PENDING SHALL be ignored.
REQ-020 After completion, the FSM SHALL spend exactly one cycle in IDLE before re-evaluating REQ-016.
REQ-021 If claim_i and completed_i are asserted together in PENDING, claim SHALL win and completed_i SHALL be dropped.
REQ-022 In edge mode, the counter SHALL increment on edge_det, decrement on an accepted claim, and stay unchanged when both occur in one cycle.
REQ-023 The counter SHALL saturate at 2^CNT_WIDTH-1; an edge_det while saturated (and no simultaneous claim) SHALL set overflow_o.
REQ-024 While edge_mode_i = 0, the counter SHALL be held at 0; overflow_o SHALL be unaffected.
REQ-025 Edges arriving in CLAIMED SHALL be counted and SHALL produce a new PENDING after completion per REQ-020.
REQ-026 Latency SHALL be: with irq_source_i high before edge 0, irq_pending_o is high in the cycle after edge SYNC_STAGES (level mode and edge mode).

Reset
REQ-027 rst_i SHALL clear the sync chain, prev, counter and overflow_o to 0 and set state to IDLE; irq_pending_o = 0, edge_count_o = 0 during and after reset.
REQ-028 Reset mid-claim SHALL abandon the claim; a later completed_i SHALL be ignored (IDLE).
REQ-029 On the first cycle after reset, an input already high SHALL be treated as a fresh rising edge.

Configuration
REQ-030 Macro PLIC_IRQ_COND_SYNC_EN: when defined, the synchronizer of REQ-013 SHALL be present.
REQ-031 Without PLIC_IRQ_COND_SYNC_EN, sync SHALL be irq_source_i directly, SYNC_STAGES SHALL be ignored, and the REQ-026 latency SHALL become the cycle after edge 0; all other behaviour SHALL be unchanged.

Verification
REQ-032 Level mode, SYNC_STAGES=2: raise the source at cycle 0 -> pending at cycle 3; claim -> pending 0; complete with the source still high -> pending again 2 cycles later.
REQ-033 Level retraction: raise the source for 4 cycles, then drop it without a claim -> pending falls SYNC_STAGES+1 cycles after the drop; count stays 0.
REQ-034 Edge mode: 3 pulses during CLAIMED -> edge_count_o=3; complete + 3 claim/complete rounds -> count 0, pending 0.
REQ-035 Edge mode, CNT_WIDTH=2: 5 edges with no claim -> edge_count_o=3, overflow_o=1 until rst_i.
REQ-036 Claim and completed together in PENDING -> state CLAIMED; rst_i asserted in CLAIMED then completed_i -> pending 0, count 0.
REQ-037 Repeat REQ-032 with PLIC_IRQ_COND_SYNC_EN undefined -> pending at cycle 1.
